pc_sequencer: RTL and testbench

- Controller that drives the pipeline's 32-bit PC register (PC_in/LE/CLR) and the IF/ID pipeline-register enable and flush.
- Each cycle it selects the next PC from four sources: sequential PC+4, branch redirect, IRQ vector and boot vector.
- It gates PC loading on hazard stalls, inserts post-redirect bubbles, and runs a boot sequence after reset.
- Sits between the hazard unit, the branch-resolution logic in ID, the interrupt source and the PC register.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pc_next_mux.sv | 48 ++++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch-stage PC sequencing logic.
//   - seq_state_e : sequencer state encodings (BOOT=0, RUN=1, FLUSH=2; 3 is illegal)
//   - pc_src_e    : next-PC source select driven by the sequencer into pc_next_mux
//   - PC_INC      : sequential instruction stride
//   - RESET_VECTOR_DEF / IRQ_VECTOR_DEF : default boot and interrupt vectors
//   - align_word  : clears the two byte-offset bits of an address
package pipe_pkg;

    typedef enum logic [1:0] {
        SEQ_BOOT  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_e;

    // HOLD re-presents the current PC so a stalled PC register sees a stable input.
    typedef enum logic [2:0] {
        PC_SRC_SEQ    = 3'd0,
        PC_SRC_HOLD   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_IRQ    = 3'd3,
        PC_SRC_BOOT   = 3'd4
    } pc_src_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEF   = 32'h0000_0018;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector.
// Ports:
//   pc_src      in   select: sequential, hold, branch, irq vector, boot vector
//   pc_cur      in   current PC (PC register output)
//   br_target   in   raw branch target; the two low bits are forced to zero
//   irq_vector  in   interrupt entry address
//   boot_vector in   address loaded at the end of boot
//   pc_next     out  selected next PC
module pc_next_mux
    import pipe_pkg::*;
(
    input  pc_src_e     pc_src,
    input  logic [31:0] pc_cur,
    input  logic [31:0] br_target,
    input  logic [31:0] irq_vector,
    input  logic [31:0] boot_vector,
    output logic [31:0] pc_next
);

    logic [31:0] br_aligned;
    logic [31:0] pc_seq;

    // Branch targets may carry byte-offset bits from the ID-stage adder;
    // instructions are word aligned, so the offset bits are dropped.
    for (genvar gi = 0; gi < 32; gi++) begin : g_align
        if (gi < 2) begin : g_low
            assign br_aligned[gi] = 1'b0;
        end else begin : g_high
            assign br_aligned[gi] = br_target[gi];
        end
    end

    // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0.
    assign pc_seq = pc_cur + PC_INC;

    always_comb begin
        pc_next = boot_vector;
        case (pc_src)
            PC_SRC_SEQ:    pc_next = pc_seq;
            PC_SRC_HOLD:   pc_next = pc_cur;
            PC_SRC_BRANCH: pc_next = br_aligned;
            PC_SRC_IRQ:    pc_next = irq_vector;
            PC_SRC_BOOT:   pc_next = boot_vector;
            default:       pc_next = boot_vector;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: chooses the next PC, gates PC loading on hazard
// stalls, squashes IF/ID after redirects and runs a boot sequence after reset.
// Ports:
//   CLK, CLR      clock (rising edge), asynchronous active-high reset
//   pc_cur        current PC from the PC register
//   stall         hazard-unit stall request
//   br_taken      branch resolved taken this cycle, br_target its address
//   irq_req       level interrupt request (held until irq_ack), irq_en enable
//   pc_next       next PC to the PC register input
//   pc_le         PC register load enable
//   if_id_le      IF/ID register load enable
//   if_id_flush   IF/ID squash (insert NOP)
//   irq_ack       one-cycle acknowledge of an accepted interrupt
//   irq_ret_addr  PC captured when the interrupt was accepted
//   seq_state     BOOT=0, RUN=1, FLUSH=2
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
    parameter int unsigned BOOT_CYCLES  = 2,   // 1..15
    parameter int unsigned FLUSH_DEPTH  = 1    // 0..7, 0 disables the squash phase
)
(
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        irq_req,
    input  logic        irq_en,
    output logic [31:0] pc_next,
    output logic        pc_le,
    output logic        if_id_le,
    output logic        if_id_flush,
    output logic        irq_ack,
    output logic [31:0] irq_ret_addr,
    output logic [1:0]  seq_state
);

    localparam logic [3:0] BOOT_LOAD  = 4'(BOOT_CYCLES - 1);
    localparam bit         HAS_FLUSH  = (FLUSH_DEPTH != 0);
    localparam logic [2:0] FLUSH_LOAD = HAS_FLUSH ? 3'(FLUSH_DEPTH - 1) : 3'd0;

    seq_state_e  state_reg, state_next;
    logic [3:0]  boot_cnt_reg, boot_cnt_next;
    logic [2:0]  flush_cnt_reg, flush_cnt_next;
    logic [31:0] irq_ret_addr_reg, irq_ret_addr_next;

    pc_src_e     pc_src_c;
    pc_src_e     pc_src_sel;
    logic        pc_le_c;
    logic        if_id_le_c;
    logic        if_id_flush_c;
    logic        irq_ack_c;
    logic        redirect_c;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_reg        <= SEQ_BOOT;
            boot_cnt_reg     <= BOOT_LOAD;
            flush_cnt_reg    <= 3'd0;
            irq_ret_addr_reg <= 32'd0;
        end else begin
            state_reg        <= state_next;
            boot_cnt_reg     <= boot_cnt_next;
            flush_cnt_reg    <= flush_cnt_next;
            irq_ret_addr_reg <= irq_ret_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        boot_cnt_next     = boot_cnt_reg;
        flush_cnt_next    = flush_cnt_reg;
        irq_ret_addr_next = irq_ret_addr_reg;
        pc_src_c          = PC_SRC_BOOT;
        pc_le_c           = 1'b0;
        if_id_le_c        = 1'b0;
        if_id_flush_c     = 1'b1;
        irq_ack_c         = 1'b0;
        redirect_c        = 1'b0;

        case (state_reg)
            SEQ_BOOT: begin
                // Hazard, branch and irq inputs are meaningless until the
                // pipeline holds real instructions, so they are ignored here.
                if (boot_cnt_reg == 4'd0) begin
                    pc_le_c    = 1'b1;
                    state_next = SEQ_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg - 4'd1;
                end
            end

            SEQ_RUN: begin
                pc_src_c      = PC_SRC_SEQ;
                pc_le_c       = 1'b1;
                if_id_le_c    = 1'b1;
                if_id_flush_c = 1'b0;
                if (br_taken) begin
                    // A resolved branch outranks a stall: the stalled
                    // instruction is on the wrong path and gets squashed.
                    pc_src_c      = PC_SRC_BRANCH;
                    if_id_flush_c = 1'b1;
                    redirect_c    = 1'b1;
                end else if (stall) begin
                    pc_src_c   = PC_SRC_HOLD;
                    pc_le_c    = 1'b0;
                    if_id_le_c = 1'b0;
                end else if (irq_req && irq_en) begin
                    pc_src_c          = PC_SRC_IRQ;
                    if_id_flush_c     = 1'b1;
                    irq_ack_c         = 1'b1;
                    irq_ret_addr_next = pc_cur;
                    redirect_c        = 1'b1;
                end
                if (redirect_c && HAS_FLUSH) begin
                    state_next     = SEQ_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end

            SEQ_FLUSH: begin
                // Instructions fetched here are on the squashed path, so any
                // branch or irq they raise is ignored; irq_req stays pending
                // and is re-evaluated once back in RUN.
                if_id_le_c    = 1'b1;
                if_id_flush_c = 1'b1;
                if (stall) begin
                    pc_src_c = PC_SRC_HOLD;
                end else begin
                    pc_src_c = PC_SRC_SEQ;
                    pc_le_c  = 1'b1;
                    if (flush_cnt_reg == 3'd0) begin
                        state_next = SEQ_RUN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg - 3'd1;
                    end
                end
            end

            default: begin
                // Unreachable encoding: restart the boot sequence cleanly.
                state_next     = SEQ_BOOT;
                boot_cnt_next  = BOOT_LOAD;
                flush_cnt_next = 3'd0;
            end
        endcase
    end

    // While CLR is held the outputs must show reset values even when the
    // reloaded boot counter is already 0 (BOOT_CYCLES=1), so CLR also
    // masks the combinational outputs.
    assign pc_src_sel = CLR ? PC_SRC_BOOT : pc_src_c;

    pc_next_mux u_pc_next_mux (
        .pc_src      (pc_src_sel),
        .pc_cur      (pc_cur),
        .br_target   (br_target),
        .irq_vector  (IRQ_VECTOR),
        .boot_vector (RESET_VECTOR),
        .pc_next     (pc_next)
    );

    assign pc_le        = pc_le_c & ~CLR;
    assign if_id_le     = if_id_le_c & ~CLR;
    assign if_id_flush  = if_id_flush_c | CLR;
    assign irq_ack      = irq_ack_c & ~CLR;
    assign irq_ret_addr = irq_ret_addr_reg;
    assign seq_state    = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic        CLK;
    logic        CLR;
    logic [31:0] pc_cur;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        irq_req;
    logic        irq_en;
    logic [31:0] pc_next;
    logic        pc_le;
    logic        if_id_le;
    logic        if_id_flush;
    logic        irq_ack;
    logic [31:0] irq_ret_addr;
    logic [1:0]  seq_state;

    typedef struct packed {
        logic        clr;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        irq;
        logic        en;
        logic [31:0] pc;
    } stim_t;

    typedef struct packed {
        logic [1:0]  st;
        logic        le;
        logic        ifle;
        logic        fl;
        logic        ack;
        logic [31:0] pc;
        logic [31:0] ret;
    } obs_t;

    typedef struct packed {
        logic chk_pc;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .IRQ_VECTOR   (32'h0000_0018),
        .BOOT_CYCLES  (2),
        .FLUSH_DEPTH  (1)
    ) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .pc_cur       (pc_cur),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .irq_req      (irq_req),
        .irq_en       (irq_en),
        .pc_next      (pc_next),
        .pc_le        (pc_le),
        .if_id_le     (if_id_le),
        .if_id_flush  (if_id_flush),
        .irq_ack      (irq_ack),
        .irq_ret_addr (irq_ret_addr),
        .seq_state    (seq_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic stim_t mk_s(input bit clr, input bit stl, input bit br,
                                   input logic [31:0] tgt, input bit irq,
                                   input bit en, input logic [31:0] pc);
        stim_t s;
        s.clr = clr; s.stall = stl; s.br = br; s.tgt = tgt;
        s.irq = irq; s.en = en; s.pc = pc;
        return s;
    endfunction

    function automatic exp_t mk_e(input bit chk, input logic [1:0] st, input bit le,
                                  input bit ifle, input bit fl, input bit ack,
                                  input logic [31:0] pc, input logic [31:0] ret);
        exp_t e;
        e.chk_pc = chk; e.o.st = st; e.o.le = le; e.o.ifle = ifle;
        e.o.fl = fl; e.o.ack = ack; e.o.pc = pc; e.o.ret = ret;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = seq_state; o.le = pc_le; o.ifle = if_id_le; o.fl = if_id_flush;
        o.ack = irq_ack; o.pc = pc_next; o.ret = irq_ret_addr;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d le=%b ifle=%b flush=%b ack=%b pc_next=%h ret=%h",
                         o.st, o.le, o.ifle, o.fl, o.ack, o.pc, o.ret);
    endfunction

    // Apply one cycle of stimulus and queue the outputs it must produce.
    task automatic drive(input stim_t s, input exp_t e);
        CLR       = s.clr;
        stall     = s.stall;
        br_taken  = s.br;
        br_target = s.tgt;
        irq_req   = s.irq;
        irq_en    = s.en;
        pc_cur    = s.pc;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s[3];
        exp_t  e[3];
        for (int i = 0; i < 3; i++) begin
            s[i] = mk_s(T, T, T, 32'h123, T, T, 32'h55);
            e[i] = mk_e(T, ST_BOOT, F, F, T, F, 32'h0, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL reset step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("reset step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_boot();
        stim_t s[2];
        exp_t  e[2];
        s[0] = mk_s(F, T, T, 32'h123, T, T, 32'h55);
        e[0] = mk_e(F, ST_BOOT, F, F, T, F, 32'h0, 32'h0);
        s[1] = mk_s(F, T, T, 32'h123, T, T, 32'h55);
        e[1] = mk_e(T, ST_BOOT, T, F, T, F, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            if (!x.chk_pc) got.pc = x.o.pc;
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL boot step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("boot step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_sequential();
        stim_t s[3];
        exp_t  e[3];
        s[0] = mk_s(F, F, F, 32'h0, F, F, 32'h100);
        e[0] = mk_e(T, ST_RUN, T, T, F, F, 32'h104, 32'h0);
        s[1] = mk_s(F, F, F, 32'h0, F, F, 32'hFFFF_FFFC);
        e[1] = mk_e(T, ST_RUN, T, T, F, F, 32'h0, 32'h0);
        s[2] = mk_s(F, F, F, 32'h0, T, F, 32'h2000);   // irq masked
        e[2] = mk_e(T, ST_RUN, T, T, F, F, 32'h2004, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL seq step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("seq step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_stall();
        stim_t s[4];
        exp_t  e[4];
        for (int i = 0; i < 3; i++) begin
            s[i] = mk_s(F, T, F, 32'h0, F, F, 32'h300);
            e[i] = mk_e(T, ST_RUN, F, F, F, F, 32'h300, 32'h0);
        end
        s[3] = mk_s(F, F, F, 32'h0, F, F, 32'h300);
        e[3] = mk_e(T, ST_RUN, T, T, F, F, 32'h304, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL stall step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("stall step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_branch();
        stim_t s[6];
        exp_t  e[6];
        // branch beats stall and irq; target is word aligned
        s[0] = mk_s(F, T, T, 32'h203, T, T, 32'h304);
        e[0] = mk_e(T, ST_RUN, T, T, T, F, 32'h200, 32'h0);
        s[1] = mk_s(F, F, F, 32'h0, T, T, 32'h200);
        e[1] = mk_e(T, ST_FLUSH, T, T, T, F, 32'h204, 32'h0);
        // back in RUN, stalled: irq still waits
        s[2] = mk_s(F, T, F, 32'h0, T, T, 32'h204);
        e[2] = mk_e(T, ST_RUN, F, F, F, F, 32'h204, 32'h0);
        s[3] = mk_s(F, F, F, 32'h0, T, T, 32'h204);
        e[3] = mk_e(T, ST_RUN, T, T, T, T, 32'h18, 32'h0);
        s[4] = mk_s(F, F, F, 32'h0, F, T, 32'h18);
        e[4] = mk_e(T, ST_FLUSH, T, T, T, F, 32'h1C, 32'h204);
        s[5] = mk_s(F, F, F, 32'h0, F, T, 32'h1C);
        e[5] = mk_e(T, ST_RUN, T, T, F, F, 32'h20, 32'h204);
        for (int i = 0; i < 6; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL branch step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("branch step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_irq();
        stim_t s[4];
        exp_t  e[4];
        s[0] = mk_s(F, F, F, 32'h0, T, T, 32'h40);
        e[0] = mk_e(T, ST_RUN, T, T, T, T, 32'h18, 32'h204);
        // FLUSH stalled: counter holds, branch and irq ignored
        s[1] = mk_s(F, T, T, 32'h500, T, T, 32'h18);
        e[1] = mk_e(F, ST_FLUSH, F, T, T, F, 32'h0, 32'h40);
        s[2] = mk_s(F, F, T, 32'h500, T, T, 32'h18);
        e[2] = mk_e(T, ST_FLUSH, T, T, T, F, 32'h1C, 32'h40);
        s[3] = mk_s(F, F, F, 32'h0, F, T, 32'h1C);
        e[3] = mk_e(T, ST_RUN, T, T, F, F, 32'h20, 32'h40);
        for (int i = 0; i < 4; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            if (!x.chk_pc) got.pc = x.o.pc;
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL irq step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("irq step %0d ok: %s", i, fmt(got));
        end
    endtask

    task automatic test_reset_mid_flush();
        stim_t s[7];
        exp_t  e[7];
        s[0] = mk_s(F, F, T, 32'h600, F, F, 32'h20);
        e[0] = mk_e(T, ST_RUN, T, T, T, F, 32'h600, 32'h40);
        s[1] = mk_s(F, T, F, 32'h0, F, F, 32'h600);
        e[1] = mk_e(F, ST_FLUSH, F, T, T, F, 32'h0, 32'h40);
        s[2] = mk_s(T, F, F, 32'h0, F, F, 32'h600);
        e[2] = mk_e(T, ST_BOOT, F, F, T, F, 32'h0, 32'h0);
        s[3] = mk_s(T, F, F, 32'h0, F, F, 32'h600);
        e[3] = mk_e(T, ST_BOOT, F, F, T, F, 32'h0, 32'h0);
        s[4] = mk_s(F, F, F, 32'h0, F, F, 32'h600);
        e[4] = mk_e(F, ST_BOOT, F, F, T, F, 32'h0, 32'h0);
        s[5] = mk_s(F, F, F, 32'h0, F, F, 32'h600);
        e[5] = mk_e(T, ST_BOOT, T, F, T, F, 32'h0, 32'h0);
        s[6] = mk_s(F, F, F, 32'h0, F, F, 32'h0);
        e[6] = mk_e(T, ST_RUN, T, T, F, F, 32'h4, 32'h0);
        for (int i = 0; i < 7; i++) begin
            exp_t x;
            obs_t got;
            @(negedge CLK);
            drive(s[i], e[i]);
            #2;
            x = exp_q.pop_front();
            got = sample();
            if (!x.chk_pc) got.pc = x.o.pc;
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL rst_flush step %0d: got %s required %s", i, fmt(got), fmt(x.o));
            end else $display("rst_flush step %0d ok: %s", i, fmt(got));
        end
    endtask

    initial begin
        CLR       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        irq_req   = 1'b0;
        irq_en    = 1'b0;
        pc_cur    = 32'h0;

        test_reset();
        test_boot();
        test_sequential();
        test_stall();
        test_branch();
        test_irq();
        test_reset_mid_flush();

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
